// File: rtl/sockit_spi_slv.sv
`timescale 1ns/1ps
// sockit SPI slave: oversamples SCLK/SS/MOSI in the clk domain, SDW-bit rx/tx word streams on MOSI/MISO.
// Optional LSB-first shifting is compiled in with SOCKIT_SPI_SLV_LSB_EN (adds the cfg_lsb port).

package sockit_spi_pkg;
    localparam int unsigned SDW = 8;
endpackage

module sockit_spi_slv #(
    parameter int unsigned SDW = sockit_spi_pkg::SDW,
    parameter int unsigned SDL = $clog2(SDW),
    parameter int unsigned SYN = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_pol,
    input  logic           cfg_pha,
`ifdef SOCKIT_SPI_SLV_LSB_EN
    input  logic           cfg_lsb,
`endif
    input  logic           spi_sclk_i,
    input  logic           spi_ss_i,
    input  logic [3:0]     spi_sio_i,
    output logic [3:0]     spi_sio_o,
    output logic [3:0]     spi_sio_e,
    input  logic           tx_vld,
    output logic           tx_rdy,
    input  logic [SDW-1:0] tx_dat,
    output logic           rx_vld,
    input  logic           rx_rdy,
    output logic [SDW-1:0] rx_dat,
    output logic           sts_ovf,
    output logic           sts_udr
);

    logic [SYN-1:0] sclk_s, ss_s, mosi_s;
    logic           sclk_d, ss_d;
    logic           sclk, ss, mosi;
    logic           lead, trail, smp, drv, ss_rise, wrap, load, lsb;
    logic [SDW-1:0] hold, tsr, rsr, ld_word;
    logic [SDL-1:0] cnt;
    logic           done_q, udr_pend, miso;
    logic           ld_first, tsr_first, tsr_next;
    logic [SDW-1:0] tsr_shift, rsr_shift;
    logic           unused_sio;

`ifdef SOCKIT_SPI_SLV_LSB_EN
    assign lsb = cfg_lsb;
`else
    assign lsb = 1'b0;
`endif

    assign unused_sio = ^spi_sio_i[3:1];

    // input synchronizers plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s <= '0;
            ss_s   <= '0;
            mosi_s <= '0;
            sclk_d <= 1'b0;
            ss_d   <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[SYN-2:0], spi_sclk_i};
            ss_s   <= {ss_s[SYN-2:0], spi_ss_i};
            mosi_s <= {mosi_s[SYN-2:0], spi_sio_i[0]};
            sclk_d <= sclk;
            ss_d   <= ss;
        end
    end

    assign sclk    = sclk_s[SYN-1];
    assign ss      = ss_s[SYN-1];
    assign mosi    = mosi_s[SYN-1];
    assign lead    = (sclk ^ sclk_d) & (sclk_d == cfg_pol);
    assign trail   = (sclk ^ sclk_d) & (sclk == cfg_pol);
    assign smp     = ss & (cfg_pha ? trail : lead);
    assign drv     = ss & (cfg_pha ? lead : trail);
    assign ss_rise = ss & ~ss_d;
    assign wrap    = ss & done_q;
    assign load    = ss_rise | wrap;

    assign ld_word   = tx_rdy ? '1 : hold;
    assign ld_first  = lsb ? ld_word[0] : ld_word[SDW-1];
    assign tsr_first = lsb ? tsr[0] : tsr[SDW-1];
    assign tsr_next  = lsb ? tsr[1] : tsr[SDW-2];
    assign tsr_shift = lsb ? {1'b0, tsr[SDW-1:1]} : {tsr[SDW-2:0], 1'b0};
    assign rsr_shift = lsb ? {mosi, rsr[SDW-1:1]} : {rsr[SDW-2:0], mosi};

    assign spi_sio_o = {2'b00, miso, 1'b0};
    assign spi_sio_e = {2'b00, ss_d, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            tx_rdy   <= 1'b1;
            tsr      <= '0;
            rsr      <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            udr_pend <= 1'b0;
            miso     <= 1'b0;
            rx_vld   <= 1'b0;
            rx_dat   <= '0;
            sts_ovf  <= 1'b0;
            sts_udr  <= 1'b0;
        end else begin
            sts_ovf <= 1'b0;
            sts_udr <= 1'b0;

            // tx holding register: emptied by a word load, filled by the tx handshake
            if (tx_vld && tx_rdy) begin
                hold <= tx_dat;
            end
            if (load && !tx_rdy) begin
                tx_rdy <= 1'b1;
            end else if (tx_vld && tx_rdy) begin
                tx_rdy <= 1'b0;
            end

            if (done_q) begin
                rx_dat  <= rsr;
                rx_vld  <= 1'b1;
                sts_ovf <= rx_vld & ~rx_rdy;
            end else if (rx_rdy) begin
                rx_vld <= 1'b0;
            end

            if (!ss) begin
                cnt      <= '0;
                done_q   <= 1'b0;
                udr_pend <= 1'b0;
                miso     <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (load) begin
                    tsr <= ld_word;
                    if (!cfg_pha) begin
                        miso <= ld_first;
                    end
                    // an empty load at wrap only counts once the next word actually starts
                    sts_udr  <= ss_rise & tx_rdy;
                    udr_pend <= wrap & tx_rdy;
                    cnt      <= '0;
                end else if (smp) begin
                    rsr <= rsr_shift;
                    if (cnt == SDL'(SDW - 1)) begin
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + SDL'(1);
                    end
                    if (udr_pend) begin
                        sts_udr  <= 1'b1;
                        udr_pend <= 1'b0;
                    end
                end else if (drv) begin
                    if (cnt == '0) begin
                        miso <= tsr_first;
                    end else begin
                        tsr  <= tsr_shift;
                        miso <= tsr_next;
                    end
                end
            end
        end
    end

endmodule
